// File: rtl/tick_gen_prog.sv
// Run-time programmable tick generator: periodic or one-shot strobes, loadable period, speed-up step.
// Define TICK_GEN_SQUARE_EN to add the `sq` square-wave output that toggles on every tick.
module tick_gen_prog #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 25000000,
    parameter int unsigned MIN_PERIOD     = 1,
    parameter int unsigned STEP           = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             speed_up,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] period,
`ifdef TICK_GEN_SQUARE_EN
    output logic [WIDTH-1:0] count,
    output logic             sq
`else
    output logic [WIDTH-1:0] count
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] MinPeriod = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] StepVal   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             terminal;

    // period_q never drops below MIN_PERIOD >= 1, so the decrement cannot wrap
    assign terminal = (count_q >= (period_q - One));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        done_d  = done_q;
        tick_d  = 1'b0;

        case (state_q)
            StIdle: begin
                count_d = '0;
                if (start && !stop) begin
                    state_d = StRun;
                    mode_d  = oneshot;
                    done_d  = 1'b0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (start) begin
                    count_d = '0;
                    mode_d  = oneshot;
                end else if (terminal) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    if (mode_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + One;
                end
            end
            StDone: begin
                count_d = '0;
                if (stop) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d = StRun;
                    mode_d  = oneshot;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
                done_d  = 1'b0;
            end
        endcase

        // A load restarts the phase without touching the FSM state
        if (load) begin
            count_d = '0;
        end

        busy_d = (state_d == StRun);
    end

    always_comb begin
        period_d = period_q;
        if (load) begin
            period_d = (period_in < MinPeriod) ? MinPeriod : period_in;
        end else if (speed_up) begin
            // Check period <= STEP first so the subtraction is only used when it cannot underflow
            if ((period_q <= StepVal) || ((period_q - StepVal) < MinPeriod)) begin
                period_d = MinPeriod;
            end else begin
                period_d = period_q - StepVal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            period_q <= DefPeriod;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
        end
    end

    assign tick   = tick_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign period = period_q;
    assign count  = count_q;

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (stop) begin
            sq_d = 1'b0;
        end else if (tick_d) begin
            sq_d = ~sq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`endif

endmodule
